// File: rtl/rfdp_pkg.sv
// -----------------------------------------------------------------------------
// rfdp_pkg
// Shared types for the rfdp ping-pong buffer controller.
//   wstate_t : producer-side state (filling a bank / stalled on two full banks)
//   rstate_t : consumer-side state (waiting for a full bank / draining one)
// -----------------------------------------------------------------------------
package rfdp_pkg;

    typedef enum logic {
        W_FILL  = 1'b0,
        W_STALL = 1'b1
    } wstate_t;

    typedef enum logic {
        R_WAIT = 1'b0,
        R_READ = 1'b1
    } rstate_t;

endpackage

// File: rtl/rfdp.sv
// -----------------------------------------------------------------------------
// rfdp
// Behavioural 1W1R register-file SRAM, one read port (A) and one write port (B).
// Chip enables are active low; read data is registered (1-cycle latency).
//   CLKA : read clock
//   CENA : read enable, active low
//   AA   : read address
//   QA   : read data, updated on the CLKA edge that samples CENA = 0
//   CLKB : write clock
//   CENB : write enable, active low
//   AB   : write address
//   DB   : write data
// -----------------------------------------------------------------------------
module rfdp #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024
) (
    input  logic                     CLKA,
    input  logic                     CENA,
    input  logic [$clog2(DEPTH)-1:0] AA,
    output logic [WIDTH-1:0]         QA,
    input  logic                     CLKB,
    input  logic                     CENB,
    input  logic [$clog2(DEPTH)-1:0] AB,
    input  logic [WIDTH-1:0]         DB
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLKA) begin
        if (!CENA) begin
            QA <= mem[AA];
        end
    end

    always_ff @(posedge CLKB) begin
        if (!CENB) begin
            mem[AB] <= DB;
        end
    end

endmodule

// File: rtl/rfdp_pingpong.sv
// -----------------------------------------------------------------------------
// rfdp_pingpong
// Ping-pong controller around one rfdp SRAM split into two banks of DEPTH/2
// words (bank = address MSB). The producer fills one bank while the consumer
// drains the other; banks swap when a bank has been completely written/read.
//   CLK      : single clock for controller and both SRAM ports
//   RST      : asynchronous active-high reset
//   wr_valid : producer word valid
//   wr_data  : producer word
//   wr_ready : current write bank not full
//   rd_req   : consumer requests one word
//   rd_gnt   : current read bank is full (request accepted when rd_req && rd_gnt)
//   rd_valid : rd_data valid (2 cycles after the accepting edge's cycle)
//   rd_data  : SRAM read data passthrough
//   rd_last  : with rd_valid, last word of a bank
//   full     : per-bank full flags
// -----------------------------------------------------------------------------
module rfdp_pingpong
    import rfdp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_req,
    output logic             rd_gnt,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last,
    output logic [1:0]       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW - 1;
    localparam int BW = DEPTH / 2;
    localparam logic [OW-1:0] LAST_OFF = OW'(BW - 1);

    wstate_t          wstate;
    rstate_t          rstate;
    logic             wbank;
    logic             rbank;
    logic [OW-1:0]    waddr;
    logic [OW-1:0]    raddr;

    // SRAM-side registers
    logic             cena;
    logic             cenb;
    logic [AW-1:0]    aa;
    logic [AW-1:0]    ab;
    logic [WIDTH-1:0] db;

    // read valid/last pipeline: [0] set on accept, [1] aligned with QA
    logic [1:0]       vpipe;
    logic [1:0]       lpipe;

    // next-state terms
    logic             wacc;
    logic             racc;
    logic             wlast;
    logic             rlast;
    logic [1:0]       full_n;
    logic             wbank_n;
    logic             rbank_n;

    assign wr_ready = (wstate == W_FILL);
    assign rd_gnt   = (rstate == R_READ);
    assign rd_valid = vpipe[1];
    assign rd_last  = lpipe[1];

    always_comb begin
        wacc   = wr_valid && wr_ready;
        racc   = rd_req && rd_gnt;
        wlast  = wacc && (waddr == LAST_OFF);
        rlast  = racc && (raddr == LAST_OFF);
        full_n = full;
        if (wlast) begin
            full_n[wbank] = 1'b1;
        end
        // clear applied after set so a same-bit collision resolves to clear
        if (rlast) begin
            full_n[rbank] = 1'b0;
        end
        wbank_n = wbank ^ wlast;
        rbank_n = rbank ^ rlast;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wstate <= W_FILL;
            rstate <= R_WAIT;
            wbank  <= 1'b0;
            rbank  <= 1'b0;
            waddr  <= '0;
            raddr  <= '0;
            full   <= '0;
            cena   <= 1'b1;
            cenb   <= 1'b1;
            aa     <= '0;
            ab     <= '0;
            db     <= '0;
            vpipe  <= '0;
            lpipe  <= '0;
        end else begin
            full  <= full_n;
            wbank <= wbank_n;
            rbank <= rbank_n;

            // offsets are exactly log2(BW) bits, so the increment wraps to
            // zero on the last word of a bank
            if (wacc) begin
                waddr <= waddr + 1'b1;
            end
            if (racc) begin
                raddr <= raddr + 1'b1;
            end

            // states are evaluated on next-cycle flags/banks so ready/grant
            // reflect a swap or release in the very next cycle
            wstate <= full_n[wbank_n] ? W_STALL : W_FILL;
            rstate <= full_n[rbank_n] ? R_READ : R_WAIT;

            cenb <= !wacc;
            if (wacc) begin
                ab <= {wbank, waddr};
                db <= wr_data;
            end

            cena <= !racc;
            if (racc) begin
                aa <= {rbank, raddr};
            end

            vpipe <= {vpipe[0], racc};
            lpipe <= {lpipe[0], rlast};
        end
    end

    rfdp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rfdp (
        .CLKA (CLK),
        .CENA (cena),
        .AA   (aa),
        .QA   (rd_data),
        .CLKB (CLK),
        .CENB (cenb),
        .AB   (ab),
        .DB   (db)
    );

endmodule

// File: tb/tb_rfdp_pingpong.sv
// -----------------------------------------------------------------------------
// tb_rfdp_pingpong
// Scoreboard bench for rfdp_pingpong (WIDTH=16, DEPTH=1024). Every accepted
// write pushes its word and expected last flag; a negedge monitor pops and
// compares whenever rd_valid is high.
// -----------------------------------------------------------------------------
module tb_rfdp_pingpong;

    localparam int WIDTH = 16;
    localparam int DEPTH = 1024;
    localparam int BW    = DEPTH / 2;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             l;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic             rd_req;
    logic             rd_gnt;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_last;
    logic [1:0]       full;

    exp_t q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   wpos    = 0;
    int   cyc     = 0;
    int   vcount  = 0;
    int   first_v = -1;
    int   last_v  = -1;

    rfdp_pingpong #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_req   (rd_req),
        .rd_gnt   (rd_gnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .full     (full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: compare each presented word against the scoreboard
    always @(negedge clk) begin
        if (rd_valid) begin
            vcount++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            if (q.size() == 0) begin
                chk("unexpected_rd_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rd_data", int'(rd_data), int'(e.d));
                chk("rd_last", int'(rd_last), int'(e.l));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int d);
        exp_t e;
        e.d = WIDTH'(d);
        e.l = ((wpos % BW) == BW - 1);
        q.push_back(e);
        wpos++;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        tick();
        tick();
        q.delete();
        wpos = 0;
        rst  = 1'b0;
    endtask

    // continuous writes; wr_ready is expected high throughout
    task automatic write_seq(input string name, input int base, input int n);
        int bad = 0;
        wr_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            wr_data = WIDTH'(base + i);
            if (wr_ready !== 1'b1) bad++;
            push_exp(base + i);
            tick();
        end
        wr_valid = 1'b0;
        chk(name, bad, 0);
    endtask

    task automatic read_hold(input int n);
        rd_req = 1'b1;
        repeat (n) tick();
        rd_req = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        for (int i = 0; i < 50 && q.size() != 0; i++) tick();
        chk(name, q.size(), 0);
        repeat (3) tick();
    endtask

    initial begin
        int n0;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_req   = 1'b0;
        #1;
        chk("reset_wr_ready", int'(wr_ready), 1);
        chk("reset_rd_gnt",   int'(rd_gnt),   0);
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_rd_last",  int'(rd_last),  0);
        chk("reset_full",     int'(full),     0);
        do_reset();

        // requests on two empty banks are ignored
        vcount = 0;
        read_hold(4);
        repeat (3) tick();
        chk("empty_no_rd_valid", vcount, 0);
        chk("empty_rd_gnt", int'(rd_gnt), 0);

        // fill bank 0
        write_seq("fill_wr_ready", 0, BW);
        chk("fill_full", int'(full), 1);
        chk("fill_wr_ready_after", int'(wr_ready), 1);
        chk("fill_rd_gnt", int'(rd_gnt), 1);

        // drain bank 0, first rd_valid two cycles after request cycle
        n0 = cyc;
        first_v = -1;
        read_hold(BW);
        chk("drain_latency", first_v - n0, 2);
        wait_drained("drain_empty_q");
        chk("drain_full", int'(full), 0);
        chk("drain_rd_gnt", int'(rd_gnt), 0);

        // double-full stall
        write_seq("dfull_wr_ready", 0, DEPTH);
        chk("dfull_wr_ready_low", int'(wr_ready), 0);
        chk("dfull_full", int'(full), 3);
        wr_valid = 1'b1;
        wr_data  = 16'hDEAD;
        repeat (5) tick();
        wr_valid = 1'b0;
        chk("dfull_ignored_full", int'(full), 3);
        chk("dfull_ignored_ready", int'(wr_ready), 0);
        read_hold(DEPTH);
        wait_drained("dfull_empty_q");
        chk("dfull_drained_full", int'(full), 0);

        // concurrent ping-pong over four banks
        vcount  = 0;
        first_v = -1;
        fork
            write_seq("pp_wr_ready", 0, 4 * BW);
            read_hold(4 * BW + BW + 100);
        join
        wait_drained("pp_empty_q");
        chk("pp_count", vcount, 4 * BW);
        chk("pp_no_gaps", last_v - first_v, 4 * BW - 1);

        // release/rewrite boundary on bank 0
        do_reset();
        write_seq("rel_fill", 16'h1000, DEPTH);
        chk("rel_full", int'(full), 3);
        for (int i = 0; i < BW; i++) push_exp(16'h2000 + i);
        n0 = cyc;
        fork
            read_hold(DEPTH);
            begin
                wr_valid = 1'b1;
                wr_data  = 16'h2000;
                for (int t = 1; t <= BW + 1; t++) begin
                    tick();
                    if (t == BW - 1) chk("rel_ready_before", int'(wr_ready), 0);
                    if (t == BW)     chk("rel_ready_after",  int'(wr_ready), 1);
                end
                for (int i = 1; i < BW; i++) begin
                    wr_data = WIDTH'(16'h2000 + i);
                    tick();
                end
                wr_valid = 1'b0;
            end
        join
        chk("rel_timing", cyc - n0, DEPTH);
        chk("rel_new_full", int'(full), 1);
        read_hold(BW);
        wait_drained("rel_empty_q");
        chk("rel_drained_full", int'(full), 0);

        // reset two cycles after a grant
        write_seq("rst_fill", 16'h3000, BW);
        rd_req = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_last",  int'(rd_last),  0);
        chk("rst_full",     int'(full),     0);
        chk("rst_wr_ready", int'(wr_ready), 1);
        chk("rst_rd_gnt",   int'(rd_gnt),   0);
        q.delete();
        wpos   = 0;
        rd_req = 1'b0;
        tick();
        rst = 1'b0;
        write_seq("rst_refill", 16'h4000, BW);
        chk("rst_refill_full", int'(full), 1);
        read_hold(BW);
        wait_drained("rst_refill_empty_q");
        chk("rst_refill_drained", int'(full), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
